// File: rtl/x7seg_arbiter.sv
// x7seg_arbiter: round-robin owner selection for one shared 4-digit hex display.
// Each grant is held for a minimum dwell of HOLD_CYCLES before it can move on.
// Optional forced release of a lone long-term owner: define X7ARB_TIMEOUT_EN.
module x7seg_arbiter #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] IDLE_X      = 16'h0000,
  parameter int unsigned MAX_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] disp_x,
`ifdef X7ARB_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        busy
);

  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic            ptr;        // requester preferred when both ask from IDLE
  logic            hold_done;
  logic [CW-1:0]   hold_inc;

  // Dwell counter saturates at HOLD_CYCLES; release is only legal once there
  assign hold_done = (hold_cnt == HOLD_MAX);
  assign hold_inc  = hold_done ? hold_cnt : hold_cnt + CW'(1);

`ifdef X7ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_MAX = CW'(MAX_CYCLES);
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_done;
  logic [CW-1:0]   tmo_inc;

  // Age of the current grant, saturating at MAX_CYCLES
  assign tmo_done = (tmo_cnt == TMO_MAX);
  assign tmo_inc  = tmo_done ? tmo_cnt : tmo_cnt + CW'(1);
`endif

  // Arbiter FSM with registered grants, busy and display value
  always_ff @(posedge clk) begin
    if (clr_n) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      disp_x   <= IDLE_X;
      hold_cnt <= '0;
      ptr      <= 1'b0;
`ifdef X7ARB_TIMEOUT_EN
      tmo_cnt  <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef X7ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 && (!req1 || !ptr)) begin
            state    <= OWN0;
            gnt0     <= 1'b1;
            gnt1     <= 1'b0;
            busy     <= 1'b1;
            disp_x   <= data0;
            hold_cnt <= '0;
            ptr      <= 1'b1;
`ifdef X7ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end else if (req1) begin
            state    <= OWN1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b1;
            busy     <= 1'b1;
            disp_x   <= data1;
            hold_cnt <= '0;
            ptr      <= 1'b0;
`ifdef X7ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
            disp_x <= IDLE_X;
          end
        end

        OWN0: begin
          if (hold_done && req1) begin
            state    <= OWN1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b1;
            busy     <= 1'b1;
            disp_x   <= data1;
            hold_cnt <= '0;
            ptr      <= 1'b0;
`ifdef X7ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end else if (hold_done && !req0) begin
            state  <= IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
            disp_x <= IDLE_X;
`ifdef X7ARB_TIMEOUT_EN
          end else if (hold_done && tmo_done) begin
            // lone owner overstayed: drop to IDLE and favour the other side
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            disp_x  <= IDLE_X;
            ptr     <= 1'b1;
            timeout <= 1'b1;
`endif
          end else begin
            disp_x   <= data0;
            hold_cnt <= hold_inc;
`ifdef X7ARB_TIMEOUT_EN
            tmo_cnt  <= tmo_inc;
`endif
          end
        end

        OWN1: begin
          if (hold_done && req0) begin
            state    <= OWN0;
            gnt0     <= 1'b1;
            gnt1     <= 1'b0;
            busy     <= 1'b1;
            disp_x   <= data0;
            hold_cnt <= '0;
            ptr      <= 1'b1;
`ifdef X7ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end else if (hold_done && !req1) begin
            state  <= IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
            disp_x <= IDLE_X;
`ifdef X7ARB_TIMEOUT_EN
          end else if (hold_done && tmo_done) begin
            // lone owner overstayed: drop to IDLE and favour the other side
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            disp_x  <= IDLE_X;
            ptr     <= 1'b0;
            timeout <= 1'b1;
`endif
          end else begin
            disp_x   <= data1;
            hold_cnt <= hold_inc;
`ifdef X7ARB_TIMEOUT_EN
            tmo_cnt  <= tmo_inc;
`endif
          end
        end

        default: begin
          state  <= IDLE;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          busy   <= 1'b0;
          disp_x <= IDLE_X;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x7seg_arbiter.sv
// tb_x7seg_arbiter: directed and random stimulus against a cycle-level model
// that tracks owner, grant age and preference as plain integers.
module tb_x7seg_arbiter;

  localparam int unsigned H  = 16;
  localparam int unsigned M  = 64;
  localparam logic [15:0] IX = 16'h0000;

  logic        clk = 1'b0;
  logic        clr_n, req0, req1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, busy;
  logic [15:0] disp_x;
`ifdef X7ARB_TIMEOUT_EN
  logic        timeout;
`endif

  x7seg_arbiter #(.HOLD_CYCLES(H), .IDLE_X(IX), .MAX_CYCLES(M)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .req0   (req0),
    .data0  (data0),
    .req1   (req1),
    .data1  (data1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .disp_x (disp_x),
`ifdef X7ARB_TIMEOUT_EN
    .timeout(timeout),
`endif
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          owner = -1;   // -1 none, else requester index
  int          age   = 0;    // cycles since the current grant was given
  int          pref  = 0;    // requester favoured on a tie from idle
  logic [15:0] m_x   = IX;
  logic        m_to  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic give(input int p);
    owner = p;
    age   = 0;
    pref  = 1 - p;
  endtask

  // One clock edge of the reference behaviour, using inputs stable at the edge
  task automatic model_edge();
    int rq[2];
    int k, o;
    rq[0] = int'(req0);
    rq[1] = int'(req1);
    m_to  = 1'b0;
    if (clr_n) begin
      owner = -1; age = 0; pref = 0;
    end else if (owner < 0) begin
      if (rq[0] != 0 && rq[1] != 0) give(pref);
      else if (rq[0] != 0)           give(0);
      else if (rq[1] != 0)           give(1);
    end else begin
      k = owner;
      o = 1 - k;
      if (age >= int'(H) && rq[o] != 0)       give(o);
      else if (age >= int'(H) && rq[k] == 0)  owner = -1;
`ifdef X7ARB_TIMEOUT_EN
      else if (age >= int'(M)) begin
        owner = -1; pref = o; m_to = 1'b1;
      end
`endif
      else age++;
    end
    m_x = (owner == 0) ? data0 : (owner == 1) ? data1 : IX;
  endtask

  task automatic check_all();
    chk("gnt0",   32'(gnt0),   32'(owner == 0));
    chk("gnt1",   32'(gnt1),   32'(owner == 1));
    chk("busy",   32'(busy),   32'(owner >= 0));
    chk("disp_x", 32'(disp_x), 32'(m_x));
    chk("excl",   32'(gnt0 & gnt1), 32'(0));
`ifdef X7ARB_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(m_to));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int to_cnt;
    clr_n = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    @(negedge clk);

    // reset then quiet display
    step(); step();
    clr_n = 1'b0;
    repeat (20) step();

    // single requester, early drop still gets full dwell
    req0 = 1'b1; data0 = 16'h1234;
    step();
    chk("first_gnt0", 32'(gnt0), 32'(1));
    chk("first_x",    32'(disp_x), 32'(16'h1234));
    step(); step();
    req0 = 1'b0;
    repeat (24) step();

    // both from reset: requester 0 first, then alternate
    clr_n = 1'b1; step(); clr_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    data0 = 16'(($urandom)); data1 = 16'hABCD;
    step();
    chk("tie_gnt0", 32'(gnt0), 32'(1));
    repeat (55) step();

    // live data update while requester 1 owns the display
    for (int i = 0; i < 40 && !(owner == 1 && age == 1); i++) step();
    chk("own1_reached", 32'(gnt1), 32'(1));
    data1 = 16'h00EF;
    step();
    chk("live_x",    32'(disp_x), 32'(16'h00EF));
    chk("live_gnt1", 32'(gnt1),   32'(1));

    // reset mid-grant of requester 0, regrant goes back to 0
    for (int i = 0; i < 40 && !(owner == 0 && age == 4); i++) step();
    chk("own0_reached", 32'(gnt0), 32'(1));
    clr_n = 1'b1;
    step();
    chk("rst_gnt0", 32'(gnt0),   32'(0));
    chk("rst_x",    32'(disp_x), 32'(IX));
    clr_n = 1'b0;
    step();
    chk("regrant0", 32'(gnt0), 32'(1));
    req0 = 1'b0; req1 = 1'b0;
    repeat (20) step();

`ifdef X7ARB_TIMEOUT_EN
    // lone holder is forced off once, then regranted
    req0 = 1'b1;
    to_cnt = 0;
    repeat (M + 4) begin
      step();
      if (timeout) to_cnt++;
    end
    chk("to_pulses", 32'(to_cnt), 32'(1));
    req0 = 1'b0;
    repeat (20) step();
`else
    to_cnt = 0;
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
      clr_n = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
